// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation,
// centre sampling of data/stop bits, one-cycle valid / frame_err strobes.
module uart_rx #(
   parameter int unsigned P = 10416
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned H  = P / 2;
   localparam int unsigned CW = $clog2(P);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_pos_q, bit_pos_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      out_d;
   logic            valid_d, frame_err_d, busy_d;

   logic            rx_m, rx_s, rx_p;
   // Counts the first clocks after reset; until rx_p holds a real sample
   // the reset value of the synchroniser could fake a falling edge.
   logic [1:0]      warm_q;
   logic            fall_c;

   // Synchroniser, edge-detect delay and post-reset warm-up counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_p   <= 1'b1;
         warm_q <= 2'd0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
         if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      end
   end

   assign fall_c = rx_p & ~rx_s & (warm_q == 2'd3);

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_pos_q <= 3'd0;
         sh_q      <= 8'h00;
         out       <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_pos_q <= bit_pos_d;
         sh_q      <= sh_d;
         out       <= out_d;
         valid     <= valid_d;
         frame_err <= frame_err_d;
         busy      <= busy_d;
      end
   end

   // Next-state, bit timing and output strobe logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_pos_d   = bit_pos_q;
      sh_d        = sh_q;
      out_d       = out;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall_c) state_d = START;
         end
         START: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(H - 1)) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_pos_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(P - 1)) begin
               sh_d  = {rx_s, sh_q[7:1]};
               cnt_d = '0;
               if (bit_pos_q == 3'd7) state_d = STOP;
               else                   bit_pos_d = bit_pos_q + 3'd1;
            end
         end
         STOP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(P - 1)) begin
               state_d = IDLE;
               if (rx_s) begin
                  out_d   = sh_q;
                  valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Bit timing restarts on every state change
      if (state_d != state_q) cnt_d = '0;

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random 8N1 frames checked against a
// frame-level timing model (event times, bytes, busy windows).
module tb_uart_rx;

   localparam int unsigned P   = 16;
   localparam int unsigned H   = P / 2;
   // Pin start edge driven just after edge t0: detection at t0+3,
   // stop sample at t0+3+H+9P, strobe visible in the following cycle.
   localparam int unsigned LAT = 3 + H + 9 * P;

   logic       clock;
   logic       reset;
   logic       rx;
   logic [7:0] out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   typedef struct {
      int unsigned t;
      bit          err;
      logic [7:0]  d;
   } ev_t;

   typedef struct {
      int unsigned rise;
      int unsigned fall;
   } bz_t;

   ev_t obs_q[$];
   ev_t exp_q[$];
   bz_t obs_b[$];
   bz_t exp_b[$];

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic [7:0]  model_out = 8'h00;
   bit          busy_prev = 1'b0;
   int unsigned rise_t = 0;

   uart_rx #(.P(P)) dut (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx),
      .out       (out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Record strobes and busy windows on the falling edge
   always @(negedge clock) begin
      if (reset) begin
         rise_t = 0;
      end else begin
         if (valid || frame_err) begin
            chk("excl", 32'(valid & frame_err), 32'd0);
            obs_q.push_back('{cyc, frame_err, out});
         end
         if (busy && !busy_prev) rise_t = cyc;
         if (!busy && busy_prev) obs_b.push_back('{rise_t, cyc});
      end
      busy_prev = busy;
   end

   task automatic send_frame(input logic [7:0] d, input bit stop_bit);
      int unsigned t0;
      @(posedge clock);
      #1 rx = 1'b0;
      t0 = cyc;
      exp_q.push_back('{t0 + LAT, !stop_bit, stop_bit ? d : model_out});
      exp_b.push_back('{t0 + 3, t0 + LAT});
      if (stop_bit) model_out = d;
      for (int i = 0; i < 8; i++) begin
         repeat (P) @(posedge clock);
         #1 rx = d[i];
      end
      repeat (P) @(posedge clock);
      #1 rx = stop_bit;
      repeat (P - 1) @(posedge clock);
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         @(posedge clock);
         #1 rx = 1'b1;
         repeat (n - 1) @(posedge clock);
      end
   endtask

   task automatic check_events(input string tag);
      chk($sformatf("%s_nev", tag), 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s_t%0d", tag, i), obs_q[i].t, exp_q[i].t);
         chk($sformatf("%s_err%0d", tag, i), 32'(obs_q[i].err), 32'(exp_q[i].err));
         chk($sformatf("%s_out%0d", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
      end
      chk($sformatf("%s_nbusy", tag), 32'(obs_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
         chk($sformatf("%s_brise%0d", tag, i), obs_b[i].rise, exp_b[i].rise);
         chk($sformatf("%s_bfall%0d", tag, i), obs_b[i].fall, exp_b[i].fall);
      end
      obs_q.delete();
      exp_q.delete();
      obs_b.delete();
      exp_b.delete();
   endtask

   task automatic chk_idle_outputs(input string tag, input logic [7:0] exp_out);
      chk($sformatf("%s_out", tag), 32'(out), 32'(exp_out));
      chk($sformatf("%s_valid", tag), 32'(valid), 32'd0);
      chk($sformatf("%s_ferr", tag), 32'(frame_err), 32'd0);
      chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
   endtask

   initial begin
      int          busy_hi;
      int unsigned n;
      logic [7:0]  ab;
      logic [7:0]  rd;
      bit          rs;
      bit          prev_ok;
      int          gap;

      // Power-on reset with an idle line
      reset = 1'b0;
      rx    = 1'b1;
      #1 reset = 1'b1;
      #1 chk_idle_outputs("por", 8'h00);
      #22 reset = 1'b0;
      idle(10);

      // Single frame 0xA5
      send_frame(8'hA5, 1'b1);
      idle(20);
      check_events("a5");
      chk("a5_hold", 32'(out), 32'(model_out));

      // Asynchronous reset mid-idle, then line held low after release
      #2 reset = 1'b1;
      rx = 1'b0;
      #1 chk_idle_outputs("rst_idle", 8'h00);
      model_out = 8'h00;
      #20 reset = 1'b0;
      busy_hi = 0;
      repeat (200) begin
         @(negedge clock);
         if (busy) busy_hi++;
      end
      chk("rst_low_busy", 32'(busy_hi), 32'd0);
      check_events("rst_low");
      idle(20);
      check_events("rst_rise");

      // Three-clock glitch is rejected at the start-bit centre
      @(posedge clock);
      #1 rx = 1'b0;
      n = cyc;
      exp_b.push_back('{n + 3, n + 3 + H});
      repeat (3) @(posedge clock);
      #1 rx = 1'b1;
      idle(30);
      check_events("glitch");
      chk("glitch_out", 32'(out), 32'(model_out));

      // Good frame followed by a framing error, line then held low
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b0);
      repeat (40) @(posedge clock);
      #1 chk("ferr_low_busy", 32'(busy), 32'd0);
      check_events("ferr");
      chk("ferr_out", 32'(out), 32'hA5);
      idle(20);
      check_events("ferr_rise");

      // Back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check_events("b2b");
      chk("b2b_out", 32'(out), 32'hFF);

      // Reset during data bit 4 of a frame
      ab = 8'hC3;
      @(posedge clock);
      #1 rx = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (P) @(posedge clock);
         #1 rx = ab[i];
      end
      repeat (H) @(posedge clock);
      #3 reset = 1'b1;
      #1 chk_idle_outputs("rst_mid", 8'h00);
      model_out = 8'h00;
      repeat (5) @(posedge clock);
      #2 reset = 1'b0;
      repeat (20) @(posedge clock);
      check_events("abort");
      idle(30);
      send_frame(8'h5A, 1'b1);
      idle(20);
      check_events("after_abort");
      chk("after_abort_out", 32'(out), 32'h5A);

      // Random frames, random stop bits and gaps
      prev_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rd  = 8'($urandom);
         rs  = ($urandom_range(0, 3) != 0);
         gap = prev_ok ? int'($urandom_range(0, 25)) : int'($urandom_range(4, 25));
         idle(gap);
         send_frame(rd, rs);
         prev_ok = rs;
      end
      idle(20);
      check_events("rand");
      chk("rand_out", 32'(out), 32'(model_out));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART side of the UART-to-I2C bridge. It is the receiving end of the 8N1 link whose transmitter drives idle-high lines: one start bit (0), eight data bits LSB first, one stop bit (1), each bit `P` clocks long. It synchronises the asynchronous `rx` pin, validates the start bit at mid-bit, and samples each data and stop bit at its centre. It presents each received byte with a one-cycle strobe to the bridge command logic and flags framing errors.

## Interface
- `P`, 10416, clocks per bit (SYSCLK/BaudRate). Legal range is `P >= 4`. H = floor(P/2).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clock`, idle high.
- `out`  out  8  last correctly framed byte. Held until the next good frame.
- `valid`  out  1  one-cycle pulse; `out` carries a new byte in the same cycle.
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flops on `rx`, both reset to 1.
  - `rx_s` is the second flop and lags `rx` by 2 clocks.
  - `rx_p` is `rx_s` delayed by one clock, reset to 1. It is used for edge detection.
- Bit counter `cnt`:
  - width is $clog2(P), unsigned;
  - cleared on every state change.
- Bit index `bit_pos` runs 0..7.
- Shift register `sh[7:0]`: each sample enters at the MSB and the register shifts right. After 8 samples, `sh[0]` holds the first bit received.
- States:
  - IDLE:
    - `cnt` is held at 0.
    - A falling edge (`rx_p==1 && rx_s==0`) moves to START.
    - A line that is already low (break, or held low after reset) is not a start.
  - START:
    - `cnt` increments each clock.
    - At `cnt==H-1`, sample `rx_s`.
    - If 0: go to DATA with `bit_pos=0`.
    - If 1: the low was a glitch; return to IDLE with no output pulse.
  - DATA:
    - `cnt` increments each clock.
    - At `cnt==P-1`, shift `rx_s` into `sh` and clear `cnt`.
    - If `bit_pos==7`, go to STOP; otherwise increment `bit_pos`.
  - STOP:
    - At `cnt==P-1`, sample `rx_s` and go to IDLE.
    - If 1: `out<=sh`, `valid<=1`.
    - If 0: `frame_err<=1` and `out` is unchanged.
- `valid` and `frame_err` are registered, high for exactly one cycle, and never high together.
- `busy` is registered and equals (next state != IDLE).
- Reset, at any time including mid-frame, takes effect immediately without waiting for a clock edge. It forces:
  - state IDLE, `cnt` 0, `bit_pos` 0, `sh` 0x00;
  - `out` 0x00, `valid` 0, `frame_err` 0, `busy` 0;
  - synchroniser and `rx_p` to 1.
- After a framing error, reception resumes only after the line returns high and falls again.

## Timing
- Let E be the clock edge at which IDLE detects the falling edge of `rx_s`. This is 2–3 clocks after the pin falls.
- The start bit is sampled at E+H.
- Data bit k (k = 0..7) is sampled at E+H+(k+1)·P.
- The stop bit is sampled at E+H+9·P. `valid` (or `frame_err`) is high in the cycle following that edge, and `busy` drops at the same edge.
- Latency from the pin's start edge to `valid` is ≈ 2 + H + 9·P clocks.
- Back-to-back frames: the FSM is in IDLE P−H clocks before the next start edge can occur. This gives no dead time, and consecutive `valid` pulses are 10·P clocks apart at nominal baud.
- Sampling at mid-bit tolerates about ±4% total baud mismatch over a frame.

## Test plan
1. Reset check.
   - Stimulus: assert `reset` mid-idle with `rx=1`.
   - Required: `out`=0x00, `valid`=`frame_err`=`busy`=0 asynchronously.
   - Then release `reset` with `rx` held 0 for 200 clocks: `busy` stays 0.
2. Single frame, P=16.
   - Stimulus: send 0xA5 (bits 1,0,1,0,0,1,0,1 after the start bit, then stop=1).
   - Required: one `valid` pulse at E+8+144+1 with `out`=0xA5; `busy` high from E+1 through E+152.
3. Glitch rejection.
   - Stimulus: `rx` low for 3 clocks, then high.
   - Required: `busy` high for 8 clocks, then 0; no `valid` or `frame_err`; `out` unchanged.
4. Framing error.
   - Stimulus: after 0xA5, send 0x3C with the stop bit 0, and hold the line low for 40 clocks.
   - Required: `frame_err` pulses once; `out` stays 0xA5; `valid` stays 0; no restart while the line stays low.
5. Back-to-back frames.
   - Stimulus: send 0x00 then 0xFF with no idle gap.
   - Required: two `valid` pulses exactly 160 clocks apart, with `out`=0x00 then 0xFF.
6. Reset mid-frame.
   - Stimulus: assert `reset` during data bit 4 of a frame, release it, let the line go idle, then send 0x5A.
   - Required: outputs clear immediately; no pulse from the aborted frame; 0x5A is received with a single `valid`.
